// File: rtl/note_sequencer_if.sv
// Control and note-output bundle between a note_sequencer and whatever drives it.
// The master side issues start/stop/mode/note_sel; the slave side returns the registered note outputs.
interface note_sequencer_if;
  logic        start;
  logic        stop;
  logic        mode;
  logic [2:0]  note_sel;
  logic [31:0] div_clk_count;
  logic [2:0]  note_idx;
  logic        tone_en;
  logic        playing;
  logic        step_pulse;

  modport master (
    output start, stop, mode, note_sel,
    input  div_clk_count, note_idx, tone_en, playing, step_pulse
  );

  modport slave (
    input  start, stop, mode, note_sel,
    output div_clk_count, note_idx, tone_en, playing, step_pulse
  );
endinterface

// File: rtl/note_sequencer.sv
// Manual/auto scale sequencer producing the divide count for the downstream clock divider.
// Optional macro NOTE_SEQUENCER_LOOP_EN: auto playback wraps from note 7 back to note 0 instead of stopping.
module note_sequencer #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned NOTE_TICKS = 25_000_000
) (
  input  logic            inclk,
  input  logic            Reset_n,
  note_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    AUTO   = 2'd2
  } state_t;

  localparam logic [31:0] TICK_LAST = 32'(NOTE_TICKS - 1);

  // Do..Do' frequencies in Hz
  function automatic logic [31:0] note_hz(input int unsigned i);
    case (i)
      0:       note_hz = 32'd523;
      1:       note_hz = 32'd587;
      2:       note_hz = 32'd659;
      3:       note_hz = 32'd698;
      4:       note_hz = 32'd783;
      5:       note_hz = 32'd880;
      6:       note_hz = 32'd987;
      default: note_hz = 32'd1046;
    endcase
  endfunction

  logic [31:0] note_table [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_note
      localparam logic [31:0] HALF_PERIOD = CLK_HZ / (32'd2 * note_hz(gi));
      assign note_table[gi] = HALF_PERIOD;
    end
  endgenerate

  state_t      state_reg;
  logic [31:0] tick_reg;
  logic [2:0]  note_idx_reg;
  logic [31:0] div_clk_count_reg;
  logic        tone_en_reg;
  logic        playing_reg;
  logic        step_pulse_reg;

  logic [2:0]  note_idx_next;
  logic        tick_done;

  assign note_idx_next = note_idx_reg + 3'd1;
  assign tick_done     = (tick_reg == TICK_LAST);

  always_ff @(posedge inclk) begin
    if (!Reset_n) begin
      state_reg         <= IDLE;
      tick_reg          <= '0;
      note_idx_reg      <= 3'd0;
      div_clk_count_reg <= note_table[0];
      tone_en_reg       <= 1'b0;
      playing_reg       <= 1'b0;
      step_pulse_reg    <= 1'b0;
    end else begin
      step_pulse_reg <= 1'b0;
      // stop has priority over a simultaneous start
      if (bus.stop) begin
        state_reg   <= IDLE;
        tick_reg    <= '0;
        tone_en_reg <= 1'b0;
        playing_reg <= 1'b0;
      end else if (bus.start) begin
        tick_reg    <= '0;
        tone_en_reg <= 1'b1;
        playing_reg <= 1'b1;
        if (bus.mode) begin
          state_reg         <= AUTO;
          note_idx_reg      <= 3'd0;
          div_clk_count_reg <= note_table[0];
        end else begin
          state_reg         <= MANUAL;
          note_idx_reg      <= bus.note_sel;
          div_clk_count_reg <= note_table[bus.note_sel];
        end
      end else begin
        case (state_reg)
          MANUAL: begin
            note_idx_reg      <= bus.note_sel;
            div_clk_count_reg <= note_table[bus.note_sel];
          end
          AUTO: begin
            if (tick_done) begin
              tick_reg       <= '0;
              step_pulse_reg <= 1'b1;
              if (note_idx_reg == 3'd7) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                note_idx_reg      <= 3'd0;
                div_clk_count_reg <= note_table[0];
`else
                // last note finished: fall silent, keep note 7 on the outputs
                state_reg   <= IDLE;
                tone_en_reg <= 1'b0;
                playing_reg <= 1'b0;
`endif
              end else begin
                note_idx_reg      <= note_idx_next;
                div_clk_count_reg <= note_table[note_idx_next];
              end
            end else begin
              tick_reg <= tick_reg + 32'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.div_clk_count = div_clk_count_reg;
  assign bus.note_idx      = note_idx_reg;
  assign bus.tone_en       = tone_en_reg;
  assign bus.playing       = playing_reg;
  assign bus.step_pulse    = step_pulse_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus queues expected output snapshots per cycle,
// a negedge monitor pops and compares them. dut0 uses NOTE_TICKS=4, dut1 uses NOTE_TICKS=1.
module tb_note_sequencer;

  logic clk = 1'b0;
  logic rst0_n;
  logic rst1_n;

  always #5 clk = ~clk;

  note_sequencer_if bus0 ();
  note_sequencer_if bus1 ();

  note_sequencer #(.CLK_HZ(50_000_000), .NOTE_TICKS(4)) dut0 (
    .inclk   (clk),
    .Reset_n (rst0_n),
    .bus     (bus0)
  );

  note_sequencer #(.CLK_HZ(50_000_000), .NOTE_TICKS(1)) dut1 (
    .inclk   (clk),
    .Reset_n (rst1_n),
    .bus     (bus1)
  );

  typedef struct {
    int unsigned cyc;
    bit          which;
    logic [31:0] cnt;
    logic [2:0]  idx;
    logic        tone;
    logic        play;
    logic        step;
    int          tag;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          tag_n = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // hand-computed 50 MHz note table
  logic [31:0] cnt_tab [8];
  initial begin
    cnt_tab[0] = 32'd47801; cnt_tab[1] = 32'd42589;
    cnt_tab[2] = 32'd37936; cnt_tab[3] = 32'd35816;
    cnt_tab[4] = 32'd31928; cnt_tab[5] = 32'd28409;
    cnt_tab[6] = 32'd25329; cnt_tab[7] = 32'd23900;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int unsigned k, input bit which, input logic [31:0] cnt,
                           input logic [2:0] idx, input logic tone, input logic play,
                           input logic step);
    exp_t e;
    e.cyc   = cyc + k;
    e.which = which;
    e.cnt   = cnt;
    e.idx   = idx;
    e.tone  = tone;
    e.play  = play;
    e.step  = step;
    e.tag   = tag_n;
    tag_n++;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        logic [37:0] act;
        logic [37:0] req;
        mon_e = exp_q[i];
        exp_q.delete(i);
        if (mon_e.which)
          act = {bus1.div_clk_count, bus1.note_idx, bus1.tone_en, bus1.playing, bus1.step_pulse};
        else
          act = {bus0.div_clk_count, bus0.note_idx, bus0.tone_en, bus0.playing, bus0.step_pulse};
        req = {mon_e.cnt, mon_e.idx, mon_e.tone, mon_e.play, mon_e.step};
        n_cmp++;
        if (mon_e.cyc != cyc || act !== req) begin
          n_bad++;
          $display("FAIL chk%0d dut%0d cyc%0d: got cnt=%0d idx=%0d tone=%b play=%b step=%b, want cnt=%0d idx=%0d tone=%b play=%b step=%b (due cyc%0d)",
                   mon_e.tag, mon_e.which, cyc, act[37:6], act[5:3], act[2], act[1], act[0],
                   mon_e.cnt, mon_e.idx, mon_e.tone, mon_e.play, mon_e.step, mon_e.cyc);
        end else begin
          $display("ok   chk%0d dut%0d cyc%0d: cnt=%0d idx=%0d tone=%b play=%b step=%b",
                   mon_e.tag, mon_e.which, cyc, act[37:6], act[5:3], act[2], act[1], act[0]);
        end
      end
    end
  end

  initial begin
    rst0_n        = 1'b0;
    rst1_n        = 1'b0;
    bus0.start    = 1'b0; bus0.stop = 1'b0; bus0.mode = 1'b0; bus0.note_sel = 3'd0;
    bus1.start    = 1'b0; bus1.stop = 1'b0; bus1.mode = 1'b0; bus1.note_sel = 3'd0;

    // 1: reset held two cycles, then released
    wait_neg(1);
    expect_at(1, 1'b0, cnt_tab[0], 3'd0, 1'b0, 1'b0, 1'b0);
    expect_at(1, 1'b1, cnt_tab[0], 3'd0, 1'b0, 1'b0, 1'b0);
    wait_neg(1);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    expect_at(1, 1'b0, cnt_tab[0], 3'd0, 1'b0, 1'b0, 1'b0);
    expect_at(2, 1'b0, cnt_tab[0], 3'd0, 1'b0, 1'b0, 1'b0);
    expect_at(1, 1'b1, cnt_tab[0], 3'd0, 1'b0, 1'b0, 1'b0);
    wait_neg(2);

    n_cmp++;
    if (bus0.div_clk_count !== 32'd47801 || bus0.note_idx !== 3'd0 ||
        bus0.tone_en !== 1'b0 || bus0.playing !== 1'b0) begin
      n_bad++;
      $display("FAIL post-reset dut0 cyc%0d: cnt=%0d idx=%0d tone=%b play=%b",
               cyc, bus0.div_clk_count, bus0.note_idx, bus0.tone_en, bus0.playing);
    end else begin
      $display("ok   post-reset dut0 cyc%0d: cnt=%0d idx=%0d", cyc, bus0.div_clk_count, bus0.note_idx);
    end

    // 2: manual mode follows note_sel, ignores mode, holds on stop
    bus0.mode = 1'b0; bus0.note_sel = 3'd5; bus0.start = 1'b1;
    expect_at(2, 1'b0, 32'd28409, 3'd5, 1'b1, 1'b1, 1'b0);
    wait_neg(1);
    bus0.start = 1'b0;
    wait_neg(1);
    bus0.note_sel = 3'd7;
    expect_at(1, 1'b0, 32'd23900, 3'd7, 1'b1, 1'b1, 1'b0);
    wait_neg(1);
    bus0.mode = 1'b1; bus0.note_sel = 3'd3;
    expect_at(1, 1'b0, 32'd35816, 3'd3, 1'b1, 1'b1, 1'b0);
    wait_neg(1);
    bus0.stop = 1'b1; bus0.note_sel = 3'd6;
    expect_at(1, 1'b0, 32'd35816, 3'd3, 1'b0, 1'b0, 1'b0);
    wait_neg(1);
    bus0.stop = 1'b0;
    expect_at(1, 1'b0, 32'd35816, 3'd3, 1'b0, 1'b0, 1'b0);
    expect_at(2, 1'b0, 32'd35816, 3'd3, 1'b0, 1'b0, 1'b0);
    wait_neg(2);

    // 3: full auto run, one note per 4 cycles
    bus0.mode = 1'b1; bus0.start = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      int i;
      bit st;
      i  = (k - 1) / 4;
      st = (k > 1) && ((k - 1) % 4 == 0);
      expect_at(k, 1'b0, cnt_tab[i], 3'(i), 1'b1, 1'b1, st);
    end
`ifdef NOTE_SEQUENCER_LOOP_EN
    expect_at(33, 1'b0, cnt_tab[0], 3'd0, 1'b1, 1'b1, 1'b1);
    expect_at(34, 1'b0, cnt_tab[0], 3'd0, 1'b1, 1'b1, 1'b0);
`else
    expect_at(33, 1'b0, cnt_tab[7], 3'd7, 1'b0, 1'b0, 1'b1);
    expect_at(34, 1'b0, cnt_tab[7], 3'd7, 1'b0, 1'b0, 1'b0);
`endif
    wait_neg(1);
    bus0.start = 1'b0;
    wait_neg(33);
    bus0.stop = 1'b1;
`ifdef NOTE_SEQUENCER_LOOP_EN
    expect_at(1, 1'b0, cnt_tab[0], 3'd0, 1'b0, 1'b0, 1'b0);
`else
    expect_at(1, 1'b0, cnt_tab[7], 3'd7, 1'b0, 1'b0, 1'b0);
`endif
    wait_neg(1);
    bus0.stop = 1'b0;
    wait_neg(1);

    // 4: start and stop together on note 3 -> stop wins, count held
    bus0.mode = 1'b1; bus0.start = 1'b1;
    expect_at(13, 1'b0, 32'd35816, 3'd3, 1'b1, 1'b1, 1'b1);
    wait_neg(1);
    bus0.start = 1'b0;
    wait_neg(12);
    bus0.start = 1'b1; bus0.stop = 1'b1;
    expect_at(1, 1'b0, 32'd35816, 3'd3, 1'b0, 1'b0, 1'b0);
    expect_at(3, 1'b0, 32'd35816, 3'd3, 1'b0, 1'b0, 1'b0);
    wait_neg(1);
    bus0.start = 1'b0; bus0.stop = 1'b0;
    wait_neg(3);

    n_cmp++;
    if (bus0.div_clk_count !== 32'd35816 || bus0.note_idx !== 3'd3 || bus0.tone_en !== 1'b0) begin
      n_bad++;
      $display("FAIL start+stop hold dut0 cyc%0d: cnt=%0d idx=%0d tone=%b",
               cyc, bus0.div_clk_count, bus0.note_idx, bus0.tone_en);
    end else begin
      $display("ok   start+stop hold dut0 cyc%0d: cnt=%0d idx=%0d", cyc, bus0.div_clk_count, bus0.note_idx);
    end

    // 5: restart into manual from auto note 2, no further step pulses
    bus0.mode = 1'b1; bus0.start = 1'b1;
    expect_at(10, 1'b0, 32'd37936, 3'd2, 1'b1, 1'b1, 1'b0);
    wait_neg(1);
    bus0.start = 1'b0;
    wait_neg(9);
    bus0.start = 1'b1; bus0.mode = 1'b0; bus0.note_sel = 3'd1;
    for (int k = 2; k <= 6; k++)
      expect_at(k, 1'b0, 32'd42589, 3'd1, 1'b1, 1'b1, 1'b0);
    wait_neg(1);
    bus0.start = 1'b0;
    wait_neg(6);
    bus0.stop = 1'b1;
    expect_at(1, 1'b0, 32'd42589, 3'd1, 1'b0, 1'b0, 1'b0);
    wait_neg(1);
    bus0.stop = 1'b0;
    wait_neg(1);

    // 6a: reset in the middle of auto note 6
    bus0.mode = 1'b1; bus0.start = 1'b1;
    expect_at(26, 1'b0, 32'd25329, 3'd6, 1'b1, 1'b1, 1'b0);
    wait_neg(1);
    bus0.start = 1'b0;
    wait_neg(25);
    rst0_n = 1'b0;
    expect_at(1, 1'b0, cnt_tab[0], 3'd0, 1'b0, 1'b0, 1'b0);
    wait_neg(1);
    rst0_n = 1'b1;
    expect_at(1, 1'b0, cnt_tab[0], 3'd0, 1'b0, 1'b0, 1'b0);
    wait_neg(2);

    n_cmp++;
    if (bus0.div_clk_count !== 32'd47801 || bus0.note_idx !== 3'd0 || bus0.playing !== 1'b0) begin
      n_bad++;
      $display("FAIL mid-auto reset dut0 cyc%0d: cnt=%0d idx=%0d play=%b",
               cyc, bus0.div_clk_count, bus0.note_idx, bus0.playing);
    end else begin
      $display("ok   mid-auto reset dut0 cyc%0d: cnt=%0d idx=%0d", cyc, bus0.div_clk_count, bus0.note_idx);
    end

    // 6b: NOTE_TICKS = 1 advances every cycle
    bus1.mode = 1'b1; bus1.start = 1'b1;
    expect_at(1, 1'b1, cnt_tab[0], 3'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 2; k <= 8; k++)
      expect_at(k, 1'b1, cnt_tab[k-1], 3'(k - 1), 1'b1, 1'b1, 1'b1);
`ifdef NOTE_SEQUENCER_LOOP_EN
    expect_at(9, 1'b1, cnt_tab[0], 3'd0, 1'b1, 1'b1, 1'b1);
    expect_at(10, 1'b1, cnt_tab[1], 3'd1, 1'b1, 1'b1, 1'b1);
`else
    expect_at(9, 1'b1, cnt_tab[7], 3'd7, 1'b0, 1'b0, 1'b1);
    expect_at(10, 1'b1, cnt_tab[7], 3'd7, 1'b0, 1'b0, 1'b0);
`endif
    wait_neg(1);
    bus1.start = 1'b0;
    wait_neg(9);
    bus1.stop = 1'b1;
`ifdef NOTE_SEQUENCER_LOOP_EN
    expect_at(1, 1'b1, cnt_tab[1], 3'd1, 1'b0, 1'b0, 1'b0);
`else
    expect_at(1, 1'b1, cnt_tab[7], 3'd7, 1'b0, 1'b0, 1'b0);
`endif
    wait_neg(1);
    bus1.stop = 1'b0;
    wait_neg(3);

    n_cmp++;
    if (bus1.tone_en !== 1'b0 || bus1.playing !== 1'b0 || bus1.step_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL idle after stop dut1 cyc%0d: tone=%b play=%b step=%b",
               cyc, bus1.tone_en, bus1.playing, bus1.step_pulse);
    end else begin
      $display("ok   idle after stop dut1 cyc%0d: cnt=%0d idx=%0d", cyc, bus1.div_clk_count, bus1.note_idx);
    end

    foreach (exp_q[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL chk%0d dut%0d: never checked, due cyc%0d, now cyc%0d",
               exp_q[i].tag, exp_q[i].which, exp_q[i].cyc, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad != 0)
      $display("*** TEST FAILED ***");
    else
      $display("*** TEST PASSED ***");
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream stage of the clock divider. Produces the 32-bit divide count (div_clk_count) and a tone enable for the audio tone path.
- Manual mode: a 3-bit switch value selects one of 8 scale notes (Do..Do').
- Auto mode: the block steps through the 8 notes, holding each for a fixed number of clock cycles.
- Runs entirely in the system clock domain; the divider consumes div_clk_count directly.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz; used to build the note table.
- NOTE_TICKS, 25_000_000, cycles each note is held in auto mode (must be >= 1).

Ports:
- inclk  input  1  system clock; all logic on posedge.
- Reset_n  input  1  synchronous active-low reset, sampled on posedge inclk.
- start  input  1  one-cycle request; begins or restarts playback and samples mode.
- stop  input  1  one-cycle request; ends playback.
- mode  input  1  0 = manual, 1 = auto; sampled only when start is accepted.
- note_sel  input  3  manual note select (0 = Do … 7 = Do').
- div_clk_count  output  32  registered divide count for the downstream divider.
- note_idx  output  3  registered index of the current note.
- tone_en  output  1  1 while a note is sounding; downstream gates audio with it.
- playing  output  1  1 in any play state.
- step_pulse  output  1  one-cycle strobe on each auto note advance.

Behaviour:
- Note table: count[i] = CLK_HZ / (2*f[i]), integer truncation, 32-bit.
- f = 523, 587, 659, 698, 783, 880, 987, 1046 Hz.
- At 50 MHz the table is 47801, 42589, 37936, 35816, 31928, 28409, 25329, 23900.
- Reset (Reset_n = 0 at a posedge):
  - state = IDLE, tick counter = 0.
  - div_clk_count = count[0] (47801), note_idx = 0.
  - tone_en = 0, playing = 0, step_pulse = 0.
  - Reset overrides everything, including mid-note in any state.
- States: IDLE, MANUAL, AUTO.
- IDLE:
  - tone_en = 0, playing = 0; div_clk_count and note_idx hold their last values.
  - start = 1 -> MANUAL if mode = 0, otherwise AUTO.
  - Entering AUTO: note_idx <= 0, div_clk_count <= count[0], tick = 0.
- MANUAL:
  - Every cycle: note_idx <= note_sel, div_clk_count <= table[note_sel].
  - Latency is 1 cycle from note_sel to output.
  - tone_en = playing = 1. Mode changes are ignored.
- AUTO:
  - tone_en = playing = 1; tick increments every cycle.
  - When tick == NOTE_TICKS-1: tick <= 0, step_pulse = 1 for that one cycle, note_idx <= note_idx+1, div_clk_count <= table[next] in the same cycle.
  - Each note is held exactly NOTE_TICKS cycles. With NOTE_TICKS = 1 the note advances every cycle.
- End of note 7: handling is set by LOOP_EN (see Optional Feature).
- stop = 1 in MANUAL or AUTO -> IDLE next cycle; tone_en and playing drop that edge; tick is cleared.
- start and stop asserted together: stop wins.
- start while already playing: restarts. Mode is re-sampled; AUTO restarts from note 0 with tick = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: NOTE_SEQUENCER_LOOP_EN.
- Defined: in AUTO, note 7 wraps to note 0 (step_pulse fires, div_clk_count = count[0]); playback continues until stop.
- Undefined: at the end of note 7's hold, step_pulse fires and state -> IDLE (tone_en = playing = 0). note_idx stays 7 and div_clk_count stays count[7].

Test Plan (CLK_HZ = 50_000_000, NOTE_TICKS = 4 unless noted):
1. Reset_n = 0 for 2 cycles, then 1 -> div_clk_count = 47801, note_idx = 0, tone_en = playing = step_pulse = 0.
2. start with mode = 0, then note_sel = 5 -> one cycle later note_idx = 5, div_clk_count = 28409, tone_en = 1. Then note_sel = 7 -> 23900.
3. start with mode = 1:
   - Notes advance every 4 cycles with a step_pulse on each advance.
   - div_clk_count sequence: 47801, 42589, 37936, 35816, 31928, 28409, 25329, 23900.
   - Without LOOP_EN: IDLE after 32 cycles. With LOOP_EN: 47801 again at cycle 32.
4. In AUTO on note 3, assert start and stop in the same cycle -> IDLE, tone_en = 0, div_clk_count holds 35816.
5. In AUTO on note 2, pulse start with mode = 0 and note_sel = 1 -> MANUAL, div_clk_count = 42589, no further step_pulse.
6. Reset_n = 0 mid-AUTO on note 6 -> next edge: IDLE, note_idx = 0, div_clk_count = 47801. With NOTE_TICKS = 1, AUTO advances one note per cycle.
